// File: rtl/rotate_feeder.sv
// ============================================================================
// Module   : rotate_feeder
// Purpose  : Packs a byte-serial stream into N-lane vectors for the rotator
//            chain and skews per-stage enables to follow each vector down it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rotate_feeder #(
    parameter int N     = 16,
    parameter int LOG2N = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic [LOG2N-1:0] in_shamt,
    input  logic             flush,
    output logic [8*N-1:0]   vec_out,
    output logic             launch,
    output logic [LOG2N-1:0] en_out,
    output logic             res_valid,
    output logic [CNTW-1:0]  launch_cnt
);

    localparam logic [LOG2N-1:0] LAST_LANE = LOG2N'(N - 1);

    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [8*N-1:0]   asm_q, asm_d;
    logic [LOG2N-1:0] shamt_q, shamt_d;
    logic [8*N-1:0]   vec_q, vec_d;
    logic [CNTW-1:0]  lcnt_q, lcnt_d;
    logic             launch_d;
    logic [LOG2N:0]   vld_q;
    logic             w_accept;

    assign in_ready = !reset && !flush;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        shamt_d  = shamt_q;
        vec_d    = vec_q;
        lcnt_d   = lcnt_q;
        launch_d = 1'b0;
        if (flush) begin
            cnt_d = '0;
        end else if (w_accept) begin
            asm_d[8*cnt_q +: 8] = in_byte;
            if (cnt_q == '0) begin
                shamt_d = in_shamt;
            end
            if (cnt_q == LAST_LANE) begin
                // Launch the buffer with the final byte already merged in.
                vec_d    = asm_d;
                launch_d = 1'b1;
                cnt_d    = '0;
                lcnt_d   = lcnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            shamt_q <= '0;
            vec_q   <= '0;
            lcnt_q  <= '0;
            vld_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            shamt_q <= shamt_d;
            vec_q   <= vec_d;
            lcnt_q  <= lcnt_d;
            vld_q   <= {vld_q[LOG2N-1:0], launch_d};
        end
    end

    // Stage k's enable rides a private k+1 deep tap so overlapping packets
    // never disturb each other.
    generate
        for (genvar k = 0; k < LOG2N; k++) begin : g_skew
            logic [k:0] tap_q;
            if (k == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) tap_q <= '0;
                    else       tap_q <= launch_d & shamt_q[0];
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) tap_q <= '0;
                    else       tap_q <= {tap_q[k-1:0], launch_d & shamt_q[k]};
                end
            end
            assign en_out[k] = tap_q[k];
        end
    endgenerate

    assign vec_out    = vec_q;
    assign launch     = vld_q[0];
    assign res_valid  = vld_q[LOG2N];
    assign launch_cnt = lcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rotate_feeder.sv
// ============================================================================
// Module   : tb_rotate_feeder
// Purpose  : Directed self-checking bench for rotate_feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rotate_feeder;

    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int CNTW  = 16;
    localparam int W     = 8 * N;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_byte = '0;
    logic [LOG2N-1:0] in_shamt = '0;
    logic             flush = 1'b0;
    logic [W-1:0]     vec_out;
    logic             launch;
    logic [LOG2N-1:0] en_out;
    logic             res_valid;
    logic [CNTW-1:0]  launch_cnt;

    int               n_cmp = 0;
    int               n_err = 0;
    int               n_launch = 0;
    logic [CNTW-1:0]  exp_cnt = '0;

    rotate_feeder #(.N(N), .LOG2N(LOG2N), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .in_shamt   (in_shamt),
        .flush      (flush),
        .vec_out    (vec_out),
        .launch     (launch),
        .en_out     (en_out),
        .res_valid  (res_valid),
        .launch_cnt (launch_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (launch) n_launch++;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic [LOG2N-1:0] sh);
        in_valid = 1'b1;
        in_byte  = b;
        in_shamt = sh;
        tick();
        in_valid = 1'b0;
    endtask

    // Non-first bytes carry the inverted shamt so a wrong capture shows up.
    task automatic send_pkt(input logic [7:0] base, input logic [LOG2N-1:0] sh);
        for (int j = 0; j < N; j++) send(base + 8'(j), (j == 0) ? sh : ~sh);
    endtask

    function automatic logic [W-1:0] mkvec(input logic [7:0] base);
        logic [W-1:0] v;
        for (int j = 0; j < N; j++) v[8*j +: 8] = base + 8'(j);
        return v;
    endfunction

    task automatic expect_pkt(input string tag, input logic [W-1:0] vec,
                              input logic [LOG2N-1:0] sh, output time t_l);
        int waited;
        logic [LOG2N-1:0] e;
        waited = 0;
        t_l = 0;
        @(negedge clk);
        while (!launch && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!launch) begin
            chk({tag, " launch timeout"}, W'(launch), W'(1));
            return;
        end
        t_l = $time;
        exp_cnt++;
        chk({tag, " vec"}, vec_out, vec);
        chk({tag, " cnt"}, W'(launch_cnt), W'(exp_cnt));
        for (int k = 0; k < LOG2N; k++) begin
            if (k > 0) @(negedge clk);
            e = '0;
            e[k] = sh[k];
            chk($sformatf("%s en@t+%0d", tag, k), W'(en_out), W'(e));
            chk($sformatf("%s res@t+%0d", tag, k), W'(res_valid), W'(0));
        end
        @(negedge clk);
        chk({tag, " res pulse"}, W'(res_valid), W'(1));
        chk({tag, " en idle"}, W'(en_out), W'(0));
        @(negedge clk);
        chk({tag, " res single"}, W'(res_valid), W'(0));
    endtask

    initial begin
        time t_a, t_b;
        int  nl;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", W'(in_ready), W'(0));
        chk("rst vec", vec_out, '0);
        chk("rst launch", W'(launch), W'(0));
        chk("rst en", W'(en_out), W'(0));
        chk("rst res", W'(res_valid), W'(0));
        chk("rst cnt", W'(launch_cnt), W'(0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("idle in_ready", W'(in_ready), W'(1));

        send_pkt(8'h00, 4'b0000);
        expect_pkt("t1", mkvec(8'h00), 4'b0000, t_a);

        send_pkt(8'h00, 4'b1011);
        expect_pkt("t2", mkvec(8'h00), 4'b1011, t_a);

        fork
            begin
                send_pkt(8'h10, 4'd3);
                send_pkt(8'h20, 4'd12);
            end
            begin
                expect_pkt("t3a", mkvec(8'h10), 4'd3, t_a);
                expect_pkt("t3b", mkvec(8'h20), 4'd12, t_b);
            end
        join
        chk("t3 spacing", W'(t_b - t_a), W'(N * 10));

        for (int j = 0; j < 7; j++) send(8'h50 + 8'(j), 4'd7);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_byte  = 8'h99;
        @(negedge clk);
        chk("t4 flush ready", W'(in_ready), W'(0));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        nl = n_launch;
        send_pkt(8'hA0, 4'd1);
        expect_pkt("t4", mkvec(8'hA0), 4'd1, t_a);
        tick();
        chk("t4 single launch", W'(n_launch), W'(nl + 1));

        for (int j = 0; j < N - 1; j++) send(8'hB0 + 8'(j), 4'd9);
        nl = n_launch;
        in_valid = 1'b1;
        flush    = 1'b1;
        in_byte  = 8'hBF;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (5) tick();
        chk("t4b no launch", W'(n_launch), W'(nl));
        send_pkt(8'hD0, 4'd2);
        expect_pkt("t4b", mkvec(8'hD0), 4'd2, t_a);

        tick();
        nl = n_launch;
        for (int j = 0; j < N; j++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (j == N - 1) chk("t5 no early launch", W'(n_launch), W'(nl));
            send(8'hC0 + 8'(j), (j == 0) ? 4'd5 : 4'hF);
        end
        expect_pkt("t5", mkvec(8'hC0), 4'd5, t_a);

        send_pkt(8'h60, 4'b1111);
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        @(negedge clk);
        chk("t6 launch", W'(launch), W'(1));
        chk("t6 vec", vec_out, mkvec(8'h60));
        tick();
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("t6 en@t+2", W'(en_out), W'(4'b0100));
        chk("t6 rst ready", W'(in_ready), W'(0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6 en cleared", W'(en_out), W'(0));
        chk("t6 res@t+3", W'(res_valid), W'(0));
        chk("t6 cnt cleared", W'(launch_cnt), W'(0));
        tick();
        @(negedge clk);
        chk("t6 res@t+4", W'(res_valid), W'(0));
        exp_cnt = '0;
        send_pkt(8'h30, 4'd6);
        expect_pkt("t6 next", mkvec(8'h30), 4'd6, t_a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
